uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_PARITY    = ST_PARITY,
    S_STOP      = ST_STOP,
    S_WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver, LSB first, one stop bit.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// IDLE      | line idle, looking for a low sample on a baud tick
// START     | confirm start bit at its middle, reject glitches
// DATA      | sample one data bit every OVERSAMPLE ticks
// PARITY    | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sample stop bit, publish byte or flag framing error
// WAIT_HIGH | line held low after bad stop bit, wait for idle level
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_idle
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 perr_nxt;
  logic                 par_bad, par_bad_nxt;
`endif

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

  assign rx_idle = (state == S_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    data_nxt    = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt    = 1'b0;
    par_bad_nxt = par_bad;
`endif
    if (baud_tick) begin
      cnt_nxt = cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt   = S_START;
            bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_nxt = 1'b0;
`endif
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt_nxt   = '0;
            state_nxt = rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt     = '0;
            shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt_nxt = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = S_PARITY;
`else
              state_nxt = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_STOP;
            if ((^shreg) != rx_s) begin
              perr_nxt    = 1'b1;
              par_bad_nxt = 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!par_bad) begin
                data_nxt  = shreg;
                valid_nxt = 1'b1;
              end
`else
              data_nxt  = shreg;
              valid_nxt = 1'b1;
`endif
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          cnt_nxt = '0;
          if (rx_s) state_nxt = S_IDLE;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      rx_data    <= data_nxt;
      rx_valid   <= valid_nxt;
      frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_nxt;
      par_bad    <= par_bad_nxt;
`endif
    end
  end

endmodule
